// File: rtl/row_scan_module.sv
// Six-digit multiplexed 7-segment row driver: double-buffered digit capture,
// leading-zero suppression and a frame-synchronous blinking decimal point.
module row_scan_module #(
    parameter logic [7:0] BLINK_FRAMES = 8'd50
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [5:0]  Column_Scan_Sig,
    input  logic [23:0] Digit_In,
    input  logic [5:0]  DP_Mask,
    input  logic        LZ_En,
    input  logic        Load,
    output logic        Busy,
    output logic [7:0]  Row_Scan_Sig,
    output logic [5:0]  Column_Out
);

    logic [5:0]  col_q, col_d;
    logic [5:0]  col_out_q, col_out_d;
    logic [23:0] shadow_dig_q, shadow_dig_d;
    logic [5:0]  shadow_dp_q, shadow_dp_d;
    logic [23:0] disp_dig_q, disp_dig_d;
    logic [5:0]  disp_dp_q, disp_dp_d;
    logic        busy_q, busy_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        blink_q, blink_d;
    logic [7:0]  row_q, row_d;

    logic        frame_start;
    logic [5:0]  supp;
    logic        lz_run;
    logic        sel_valid;
    logic [2:0]  sel_idx;
    logic [3:0]  sel_nib;

    // Active-low a..g; anything above 9 shows a dash (only g lit).
    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h3F;
        endcase
    endfunction

    assign frame_start = (Column_Scan_Sig == 6'b111110) && (col_q != 6'b111110);

    always_comb begin
        col_d        = Column_Scan_Sig;
        col_out_d    = col_q;
        shadow_dig_d = shadow_dig_q;
        shadow_dp_d  = shadow_dp_q;
        disp_dig_d   = disp_dig_q;
        disp_dp_d    = disp_dp_q;
        busy_d       = busy_q;
        frame_cnt_d  = frame_cnt_q;
        blink_d      = blink_q;

        // Display only changes at frame start, so a frame is never torn.
        if (frame_start && busy_q) begin
            disp_dig_d = shadow_dig_q;
            disp_dp_d  = shadow_dp_q;
            busy_d     = 1'b0;
        end
        if (Load) begin
            shadow_dig_d = Digit_In;
            shadow_dp_d  = DP_Mask;
            busy_d       = 1'b1;
        end
        if (frame_start) begin
            if (frame_cnt_q == BLINK_FRAMES - 8'd1) begin
                frame_cnt_d = 8'd0;
                blink_d     = ~blink_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 8'd1;
            end
        end
    end

    // A digit is blanked while it and every more significant digit are zero.
    always_comb begin
        supp   = 6'b0;
        lz_run = LZ_En;
        for (int i = 5; i >= 1; i--) begin
            lz_run  = lz_run && (disp_dig_q[4*i +: 4] == 4'd0);
            supp[i] = lz_run;
        end
    end

    always_comb begin
        sel_valid = 1'b1;
        sel_idx   = 3'd0;
        case (col_q)
            6'b111110: sel_idx = 3'd0;
            6'b111101: sel_idx = 3'd1;
            6'b111011: sel_idx = 3'd2;
            6'b110111: sel_idx = 3'd3;
            6'b101111: sel_idx = 3'd4;
            6'b011111: sel_idx = 3'd5;
            default:   sel_valid = 1'b0;
        endcase
        sel_nib = disp_dig_q[{sel_idx, 2'b00} +: 4];

        if (!sel_valid || supp[sel_idx])
            row_d = 8'hFF;
        else
            row_d = {~(disp_dp_q[sel_idx] & blink_q), seg7(sel_nib)};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            col_q        <= 6'h3F;
            col_out_q    <= 6'h3F;
            shadow_dig_q <= 24'h0;
            shadow_dp_q  <= 6'h0;
            disp_dig_q   <= 24'h0;
            disp_dp_q    <= 6'h0;
            busy_q       <= 1'b0;
            frame_cnt_q  <= 8'd0;
            blink_q      <= 1'b0;
            row_q        <= 8'hFF;
        end else begin
            col_q        <= col_d;
            col_out_q    <= col_out_d;
            shadow_dig_q <= shadow_dig_d;
            shadow_dp_q  <= shadow_dp_d;
            disp_dig_q   <= disp_dig_d;
            disp_dp_q    <= disp_dp_d;
            busy_q       <= busy_d;
            frame_cnt_q  <= frame_cnt_d;
            blink_q      <= blink_d;
            row_q        <= row_d;
        end
    end

    assign Busy         = busy_q;
    assign Row_Scan_Sig = row_q;
    assign Column_Out   = col_out_q;

endmodule

// File: tb/tb_row_scan_module.sv
// Directed self-checking bench for row_scan_module (blink period shortened to 4 frames).
module tb_row_scan_module;

    logic        CLK = 1'b0;
    logic        RST;
    logic [5:0]  Column_Scan_Sig;
    logic [23:0] Digit_In;
    logic [5:0]  DP_Mask;
    logic        LZ_En;
    logic        Load;
    logic        Busy;
    logic [7:0]  Row_Scan_Sig;
    logic [5:0]  Column_Out;

    int n_checks = 0;
    int n_errors = 0;

    row_scan_module #(.BLINK_FRAMES(8'd4)) dut (
        .CLK(CLK), .RST(RST), .Column_Scan_Sig(Column_Scan_Sig), .Digit_In(Digit_In),
        .DP_Mask(DP_Mask), .LZ_En(LZ_En), .Load(Load), .Busy(Busy),
        .Row_Scan_Sig(Row_Scan_Sig), .Column_Out(Column_Out)
    );

    always #5 CLK = ~CLK;

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Select digit i, wait the two-cycle pipeline, check segments and column.
    task automatic show_digit(input int i, input logic [7:0] exp, input string tag);
        logic [5:0] s;
        s = 6'b1 << i;
        Column_Scan_Sig = ~s;
        cyc();
        cyc();
        chk({tag, "_row"}, Row_Scan_Sig, exp);
        chk({tag, "_col"}, {2'b0, Column_Out}, {2'b0, ~s});
    endtask

    initial begin
        RST = 1'b1; Column_Scan_Sig = 6'h3F; Digit_In = 24'h0; DP_Mask = 6'h0;
        LZ_En = 1'b0; Load = 1'b0;
        cyc(); cyc();
        chk("rst_row", Row_Scan_Sig, 8'hFF);
        chk("rst_col", {2'b0, Column_Out}, 8'h3F);
        chk("rst_busy", {7'b0, Busy}, 8'h00);
        RST = 1'b0;
        cyc();

        // first frame after reset: zeros, then leading-zero blanking
        show_digit(0, 8'hC0, "boot_d0");
        LZ_En = 1'b1;
        show_digit(5, 8'hFF, "boot_lz_d5");
        show_digit(0, 8'hC0, "boot_lz_d0");
        LZ_En = 1'b0;

        // mid-frame load, applied at next frame start
        show_digit(3, 8'hC0, "pre_d3");
        Digit_In = 24'h123456; Load = 1'b1;
        cyc();
        Load = 1'b0;
        chk("ld_busy", {7'b0, Busy}, 8'h01);
        show_digit(4, 8'hC0, "ld_hold_d4");
        chk("ld_busy_hold", {7'b0, Busy}, 8'h01);
        show_digit(0, 8'h82, "ld_d0");
        chk("ld_busy_clr", {7'b0, Busy}, 8'h00);
        show_digit(5, 8'hF9, "ld_d5");

        // back-to-back loads: last wins
        show_digit(2, 8'h99, "old_d2");
        Digit_In = 24'h000111; Load = 1'b1;
        cyc();
        Digit_In = 24'h000222;
        cyc();
        Load = 1'b0;
        chk("lw_busy", {7'b0, Busy}, 8'h01);
        LZ_En = 1'b1;
        show_digit(0, 8'hA4, "lw_d0");
        chk("lw_busy_clr", {7'b0, Busy}, 8'h00);
        show_digit(1, 8'hA4, "lw_d1");
        show_digit(2, 8'hA4, "lw_d2");
        show_digit(3, 8'hFF, "lw_d3");
        show_digit(4, 8'hFF, "lw_d4");
        show_digit(5, 8'hFF, "lw_d5");
        LZ_En = 1'b0;

        // load coincident with frame start while busy
        Digit_In = 24'h111111; Load = 1'b1;
        cyc();
        Column_Scan_Sig = 6'b111110; Digit_In = 24'h999999;
        cyc();
        Load = 1'b0;
        cyc();
        chk("co_d0", Row_Scan_Sig, 8'hF9);
        chk("co_busy", {7'b0, Busy}, 8'h01);
        show_digit(3, 8'hF9, "co_d3");
        show_digit(0, 8'h90, "co_next_d0");
        chk("co_busy_clr", {7'b0, Busy}, 8'h00);

        // invalid column patterns and hex-digit dashes
        Column_Scan_Sig = 6'h3F;
        cyc(); cyc();
        chk("inv3f_row", Row_Scan_Sig, 8'hFF);
        chk("inv3f_col", {2'b0, Column_Out}, 8'h3F);
        Column_Scan_Sig = 6'b111100;
        cyc(); cyc();
        chk("inv3c_row", Row_Scan_Sig, 8'hFF);
        chk("inv3c_col", {2'b0, Column_Out}, 8'h3C);
        Digit_In = 24'hFEDCBA; Load = 1'b1;
        cyc();
        Load = 1'b0;
        show_digit(0, 8'hBF, "dash_d0");
        show_digit(5, 8'hBF, "dash_d5");

        // reset dominates pending shadow, load and frame start
        Column_Scan_Sig = 6'b011111;
        Digit_In = 24'h888888; Load = 1'b1;
        cyc();
        chk("rb_busy", {7'b0, Busy}, 8'h01);
        RST = 1'b1; Column_Scan_Sig = 6'b111110;
        cyc();
        chk("rb_busy_clr", {7'b0, Busy}, 8'h00);
        chk("rb_row", Row_Scan_Sig, 8'hFF);
        chk("rb_col", {2'b0, Column_Out}, 8'h3F);
        RST = 1'b0; Load = 1'b0;
        cyc(); cyc();
        chk("rb_d0", Row_Scan_Sig, 8'hC0);
        show_digit(5, 8'hC0, "rb_d5");
        show_digit(0, 8'hC0, "rb_d0b");
        chk("rb_busy_idle", {7'b0, Busy}, 8'h00);

        // blink: fresh reset, dp on digit2 toggles every 4 frame starts
        RST = 1'b1; Column_Scan_Sig = 6'h3F;
        cyc();
        RST = 1'b0;
        Digit_In = 24'h000500; DP_Mask = 6'b000100; Load = 1'b1;
        cyc();
        Load = 1'b0;
        for (int f = 0; f < 12; f++) begin
            show_digit(0, 8'hC0, $sformatf("bl%0d_d0", f));
            show_digit(2, ((((f + 1) / 4) % 2) == 1) ? 8'h12 : 8'h92, $sformatf("bl%0d_d2", f));
        end

        // blanked digit also hides its dp (blink phase is 1 here)
        Digit_In = 24'h000500; DP_Mask = 6'b001100; Load = 1'b1;
        cyc();
        Load = 1'b0; LZ_En = 1'b1;
        show_digit(0, 8'hC0, "lzdp_d0");
        show_digit(3, 8'hFF, "lzdp_d3");
        show_digit(2, 8'h12, "lzdp_d2");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
